// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM pre-processing chain.
//   SAMPLE_WIDTH : width of the signed sample stream from the HPF stage
//   state_t      : beat detector FSM encoding (BELOW / ABOVE / REFR)
package bpm_pkg;

    localparam int SAMPLE_WIDTH = 10;

    typedef enum logic [1:0] {
        BELOW = 2'd0,
        ABOVE = 2'd1,
        REFR  = 2'd2
    } state_t;

endpackage

// File: rtl/ibi_counter.sv
// Inter-beat interval counter.
// Counts en-samples since the last beat and publishes the interval on the next beat.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : sample-valid strobe; nothing advances when low
//   beat       : beat detected on the current en sample (already qualified by en)
//   ibi        : samples between the last two beats, held until the next beat
//   ibi_valid  : at least two beats seen and the interval did not saturate
module ibi_counter #(
    parameter int IBI_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             beat,
    output logic [IBI_W-1:0] ibi,
    output logic             ibi_valid
);

    localparam logic [IBI_W-1:0] CNT_MAX = '1;

    logic [IBI_W-1:0] cnt;
    logic             have_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ibi       <= '0;
            ibi_valid <= 1'b0;
            have_prev <= 1'b0;
        end else if (en) begin
            if (beat) begin
                // A saturated interval cannot be represented; ibi is capped and
                // flagged invalid so the BPM stage ignores it.
                ibi       <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
                ibi_valid <= have_prev && (cnt != CNT_MAX);
                cnt       <= '0;
                have_prev <= 1'b1;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/beat_detector.sv
// Heart-beat detector: threshold crossing with hysteresis and a refractory window.
// Emits a one-cycle beat pulse plus the inter-beat interval in samples.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : sample-valid strobe; all state advances only when high
//   x_in       : signed sample from the HPF stage
//   beat_pulse : one-cycle pulse, the cycle after the en sample that crossed
//   ibi        : samples between the last two beats
//   ibi_valid  : ibi is meaningful
//   thr_out    : current detection threshold
// Build option:
//   ADAPTIVE_THRESH_EN : threshold follows a running average of beat peaks
//                        (floor THRESH); undefined gives a fixed THRESH.
// Valid/ready note: there is no backpressure; en is a pure valid strobe and
// every en=1 cycle consumes exactly one sample.
module beat_detector
    import bpm_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_WIDTH,
    parameter int THRESH  = 100,
    parameter int HYST    = 20,
    parameter int REFRACT = 8,
    parameter int IBI_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x_in,
    output logic                    beat_pulse,
    output logic [IBI_W-1:0]        ibi,
    output logic                    ibi_valid,
    output logic signed [WIDTH-1:0] thr_out
);

    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
    localparam logic [RW-1:0]           REFR_LOAD = RW'(REFRACT - 1);
    localparam logic signed [WIDTH-1:0] THRESH_S  = WIDTH'(THRESH);
    localparam logic signed [WIDTH:0]   HYST_S    = (WIDTH + 1)'(HYST);

    state_t                  state, state_next;
    logic [RW-1:0]           refr;
    logic                    beat_fire;
    logic                    exit_fire;
    logic signed [WIDTH-1:0] thr;
    logic signed [WIDTH:0]   x_ext;
    logic signed [WIDTH:0]   thr_ext;
    logic signed [WIDTH:0]   thr_lo;

    // One extra bit so thr-HYST never wraps for thresholds near the rails.
    assign x_ext   = x_in;
    assign thr_ext = thr;
    assign thr_lo  = thr_ext - HYST_S;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BELOW;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; only en samples move the FSM, one transition per sample.
    always_comb begin
        state_next = state;
        if (en) begin
            case (state)
                BELOW:   if (x_ext >= thr_ext) state_next = ABOVE;
                ABOVE:   if (x_ext < thr_lo)   state_next = REFR;
                REFR:    if (refr == '0)       state_next = BELOW;
                default: state_next = BELOW;
            endcase
        end
    end

    // Output decode
    always_comb begin
        beat_fire = 1'b0;
        exit_fire = 1'b0;
        if (en && (state == BELOW) && (state_next == ABOVE)) beat_fire = 1'b1;
        if (en && (state == ABOVE) && (state_next == REFR))  exit_fire = 1'b1;
    end

    // Refractory down-counter: loaded on exit, reaching 0 releases the FSM next sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refr <= '0;
        end else if (exit_fire) begin
            refr <= REFR_LOAD;
        end else if (en && (state == REFR) && (refr != '0)) begin
            refr <= refr - 1'b1;
        end
    end

    // beat_fire already carries en, so en=0 cycles always clear the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_pulse <= 1'b0;
        end else begin
            beat_pulse <= beat_fire;
        end
    end

`ifdef ADAPTIVE_THRESH_EN
    localparam int AW = WIDTH + 2;
    localparam logic signed [AW-1:0] THRESH_A  = AW'(THRESH);
    localparam logic signed [AW-1:0] AVG_RESET = AW'(2 * THRESH);

    logic signed [WIDTH-1:0] peak;
    logic signed [WIDTH-1:0] thr_r;
    logic signed [AW-1:0]    peak_ext;
    logic signed [AW-1:0]    avg;
    logic signed [AW-1:0]    avg_next;
    logic signed [AW-1:0]    avg_half;
    logic signed [AW-1:0]    thr_wide;

    assign peak_ext = peak;
    assign avg_next = avg + ((peak_ext - avg) >>> 2);
    assign avg_half = avg_next >>> 1;
    assign thr_wide = (avg_half > THRESH_A) ? avg_half : THRESH_A;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak  <= '0;
            avg   <= AVG_RESET;
            thr_r <= THRESH_S;
        end else begin
            if (beat_fire) begin
                peak <= x_in;
            end else if (en && (state == ABOVE) && (x_in > peak)) begin
                peak <= x_in;
            end
            // avg and thr both take the new value on the exit edge, so thr
            // is visible the cycle after the exit sample.
            if (exit_fire) begin
                avg   <= avg_next;
                thr_r <= thr_wide[WIDTH-1:0];
            end
        end
    end

    assign thr = thr_r;
`else
    assign thr = THRESH_S;
`endif

    assign thr_out = thr;

    ibi_counter #(
        .IBI_W (IBI_W)
    ) u_ibi_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .beat      (beat_fire),
        .ibi       (ibi),
        .ibi_valid (ibi_valid)
    );

endmodule

// File: tb/tb_beat_detector.sv
// Bench for beat_detector: directed sample stream; expected beats are queued
// by the driver and checked by an independent monitor on the falling edge.
module tb_beat_detector;

    localparam int WIDTH = 10;
    localparam int IBI_W = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic signed [WIDTH-1:0] x_in;
    logic                    beat_pulse;
    logic [IBI_W-1:0]        ibi;
    logic                    ibi_valid;
    logic signed [WIDTH-1:0] thr_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int cyc      = 0;

    // {chk_ibi, ibi_valid, ibi} and the cycle the pulse must appear in
    logic [IBI_W+1:0] exp_q[$];
    int               cyc_q[$];

    beat_detector dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x_in       (x_in),
        .beat_pulse (beat_pulse),
        .ibi        (ibi),
        .ibi_valid  (ibi_valid),
        .thr_out    (thr_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per observed pulse.
    logic [IBI_W+1:0] m_e;
    int               m_c;
    always @(negedge clk) begin
        if (!rst) begin
            if (beat_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(beat_pulse), 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    m_c = cyc_q.pop_front();
                    n_beats++;
                    check("beat_cycle", cyc, m_c);
                    if (m_e[IBI_W+1]) check("ibi", 32'(ibi), 32'(m_e[IBI_W-1:0]));
                    check("ibi_valid", 32'(ibi_valid), 32'(m_e[IBI_W]));
                    check("thr_out", 32'(thr_out), 32'd100);
                end
            end else if (exp_q.size() > 0 && cyc_q[0] < cyc) begin
                m_e = exp_q.pop_front();
                m_c = cyc_q.pop_front();
                check("missing_beat", 32'(beat_pulse), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // en=0 gap cycles carry a large sample that must be ignored.
    task automatic gap(input int maxgap);
        int n;
        n = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (n) begin
            en   = 1'b0;
            x_in = WIDTH'($urandom_range(300, 200));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input int x, input int maxgap);
        en   = 1'b1;
        x_in = WIDTH'(x);
        @(posedge clk);
        #1;
        en = 1'b0;
        gap(maxgap);
    endtask

    task automatic drv_b(input int x, input int e_ibi, input bit e_valid, input bit chk_ibi, input int maxgap);
        exp_q.push_back({chk_ibi, e_valid, IBI_W'(e_ibi)});
        cyc_q.push_back(cyc + 1);
        drv(x, maxgap);
    endtask

    task automatic zeros(input int n, input int maxgap);
        for (int i = 0; i < n; i++) drv(0, maxgap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        x_in = WIDTH'(300);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_beat_pulse", 32'(beat_pulse), 32'd0);
            check("rst_ibi", 32'(ibi), 32'd0);
            check("rst_ibi_valid", 32'(ibi_valid), 32'd0);
            check("rst_thr_out", 32'(thr_out), 32'd100);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        en   = 1'b0;
        x_in = '0;

        // first beat, plus non-crossing values (negative, threshold-1)
        zeros(10, 0);                  // s0-9
        drv_b(150, 11, 1'b0, 1'b1, 0); // s10
        drv(150, 0);                   // s11
        drv(150, 0);                   // s12
        zeros(17, 0);                  // s13-29
        drv(-300, 0);                  // s30
        zeros(9, 0);                   // s31-39
        drv(99, 0);                    // s40
        zeros(19, 0);                  // s41-59
        // interval, exactly-at-threshold crossing, en=0 gaps
        drv_b(100, 50, 1'b1, 1'b1, 0); // s60
        zeros(49, 2);                  // s61-109
        drv_b(150, 50, 1'b1, 1'b1, 2); // s110
        zeros(39, 0);                  // s111-149
        // hysteresis: only one beat for the whole excursion
        drv_b(110, 40, 1'b1, 1'b1, 0); // s150
        drv(95, 0);
        drv(85, 0);
        drv(110, 0);
        drv(80, 0);
        drv(70, 0);                    // s155 exit
        zeros(14, 0);                  // s156-169
        drv_b(150, 20, 1'b1, 1'b1, 0); // s170
        zeros(29, 0);                  // s171-199
        // refractory window
        drv_b(150, 30, 1'b1, 1'b1, 0); // s200
        drv(150, 0);                   // s201
        drv(0, 0);                     // s202 exit
        zeros(2, 0);                   // s203-204
        drv(150, 0);                   // s205 ignored
        zeros(4, 0);                   // s206-209
        drv(150, 0);                   // s210 last refractory sample, ignored
        drv_b(150, 11, 1'b1, 1'b1, 0); // s211
        zeros(38, 0);                  // s212-249
        // saturation
        drv_b(150, 39, 1'b1, 1'b1, 0); // s250
        zeros(5000, 0);                // s251-5250
        drv_b(150, 0, 1'b0, 1'b0, 0);  // s5251 saturated interval
        drv(-512, 0);                  // s5252 exit
        zeros(38, 0);                  // s5253-5290
        drv_b(150, 40, 1'b1, 1'b1, 0); // s5291
        zeros(12, 0);

        // reset right after a crossing edge: pending pulse must vanish
        en   = 1'b1;
        x_in = WIDTH'(150);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        en   = 1'b0;
        x_in = '0;
        @(negedge clk);
        check("midrst_beat_pulse", 32'(beat_pulse), 32'd0);
        check("midrst_ibi", 32'(ibi), 32'd0);
        check("midrst_ibi_valid", 32'(ibi_valid), 32'd0);
        check("midrst_thr_out", 32'(thr_out), 32'd100);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // history cleared: first beat after reset is not valid
        zeros(5, 0);
        drv_b(150, 6, 1'b0, 1'b1, 0);
        zeros(12, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("beat_count", n_beats, 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
